instruction_fetch: RTL and testbench

// - IF stage of the RISC-V core; sits directly upstream of the asynchronous instruction ROM.
// - Holds the PC and drives the ROM word address; captures the returned word in the same cycle.
// - Registers {PC, PC+4, instruction, valid} into the IF/ID pipeline register for decode.
// - Handles pipeline stall and branch/jump redirect with flush.

---
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - IF stage bus: hazard/redirect inputs, ROM port and IF/ID outputs
interface instruction_fetch_if #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32
);
  localparam int AW = $clog2(TAM_POSICIONES);

  logic                   STALL;
  logic                   BRANCH_TAKEN;
  logic [TAM_PALABRA-1:0] BRANCH_TARGET;
  logic [TAM_PALABRA-1:0] INSTRUCTION_IN;
  logic [AW-1:0]          INS_ADDRESS;
  logic [TAM_PALABRA-1:0] PC;
  logic [TAM_PALABRA-1:0] IF_ID_PC;
  logic [TAM_PALABRA-1:0] IF_ID_PC4;
  logic [TAM_PALABRA-1:0] IF_ID_INSTRUCTION;
  logic                   IF_ID_VALID;
  logic                   EXC_MISALIGN;

  // Environment side: hazard unit, branch unit, instruction ROM and decode
  modport master (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, INSTRUCTION_IN,
    input  INS_ADDRESS, PC, IF_ID_PC, IF_ID_PC4, IF_ID_INSTRUCTION, IF_ID_VALID, EXC_MISALIGN
  );

  // Fetch stage side
  modport slave (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, INSTRUCTION_IN,
    output INS_ADDRESS, PC, IF_ID_PC, IF_ID_PC4, IF_ID_INSTRUCTION, IF_ID_VALID, EXC_MISALIGN
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V IF stage with PC, async ROM address and IF/ID register; option FETCH_MISALIGN_EN
module instruction_fetch #(
  parameter int                     TAM_POSICIONES = 1024,
  parameter int                     TAM_PALABRA    = 32,
  parameter logic [TAM_PALABRA-1:0] RESET_PC       = 32'h00000000,
  parameter logic [TAM_PALABRA-1:0] NOP_INSTR      = 32'h00000013
) (
  input  logic             CLK,
  input  logic             RST,
  instruction_fetch_if.slave bus
);
  localparam int AW = $clog2(TAM_POSICIONES);

  logic [TAM_PALABRA-1:0] pc_q, pc_d;
  logic [TAM_PALABRA-1:0] if_id_pc_q, if_id_pc_d;
  logic [TAM_PALABRA-1:0] if_id_pc4_q, if_id_pc4_d;
  logic [TAM_PALABRA-1:0] if_id_instr_q, if_id_instr_d;
  logic                   if_id_valid_q, if_id_valid_d;
  logic [TAM_PALABRA-1:0] pc_plus4;

  // Wraps modulo 2^TAM_PALABRA naturally
  assign pc_plus4 = pc_q + TAM_PALABRA'(4);

  // ROM is asynchronous; addresses beyond its depth alias by truncation
  assign bus.INS_ADDRESS       = pc_q[AW+1:2];
  assign bus.PC                = pc_q;
  assign bus.IF_ID_PC          = if_id_pc_q;
  assign bus.IF_ID_PC4         = if_id_pc4_q;
  assign bus.IF_ID_INSTRUCTION = if_id_instr_q;
  assign bus.IF_ID_VALID       = if_id_valid_q;

`ifdef FETCH_MISALIGN_EN
  logic exc_q, exc_d;
  assign bus.EXC_MISALIGN = exc_q;
`else
  assign bus.EXC_MISALIGN = 1'b0;
`endif

  // Next-state: redirect beats stall beats normal sequential fetch
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
`ifdef FETCH_MISALIGN_EN
    exc_d         = 1'b0;
`endif
    if (bus.BRANCH_TAKEN) begin
      // Wrong-path fetch is squashed: IF/ID becomes a bubble
      if_id_pc_d    = '0;
      if_id_pc4_d   = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
      if (bus.BRANCH_TARGET[1:0] != 2'b00) begin
        pc_d  = pc_q;
        exc_d = 1'b1;
      end else begin
        pc_d  = bus.BRANCH_TARGET;
      end
`else
      pc_d = bus.BRANCH_TARGET & ~TAM_PALABRA'(3);
`endif
    end else if (!bus.STALL) begin
      pc_d          = pc_plus4;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_instr_d = bus.INSTRUCTION_IN;
      if_id_valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers; reset overrides any branch or stall
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  // One-cycle misaligned-target exception pulse
  always_ff @(posedge CLK) begin
    if (RST) exc_q <= 1'b0;
    else     exc_q <= exc_d;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] rom [1024];

  always #5 CLK = ~CLK;

  instruction_fetch_if #(.TAM_POSICIONES(1024), .TAM_PALABRA(32)) bus0 ();
  instruction_fetch_if #(.TAM_POSICIONES(1024), .TAM_PALABRA(32)) bus1 ();

  instruction_fetch #(
    .TAM_POSICIONES(1024), .TAM_PALABRA(32),
    .RESET_PC(32'h00000000), .NOP_INSTR(NOP)
  ) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));

  instruction_fetch #(
    .TAM_POSICIONES(1024), .TAM_PALABRA(32),
    .RESET_PC(32'hFFFFFFFC), .NOP_INSTR(NOP)
  ) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  assign bus0.INSTRUCTION_IN = rom[bus0.INS_ADDRESS];
  assign bus1.INSTRUCTION_IN = rom[bus1.INS_ADDRESS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] instr, input logic valid);
    check({tag, ".pc"},    bus0.IF_ID_PC, pc);
    check({tag, ".pc4"},   bus0.IF_ID_PC4, pc4);
    check({tag, ".instr"}, bus0.IF_ID_INSTRUCTION, instr);
    check({tag, ".valid"}, {31'd0, bus0.IF_ID_VALID}, {31'd0, valid});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA0000000 + i;
    RST = 1'b1;
    bus0.STALL = 1'b0; bus0.BRANCH_TAKEN = 1'b0; bus0.BRANCH_TARGET = '0;
    bus1.STALL = 1'b0; bus1.BRANCH_TAKEN = 1'b0; bus1.BRANCH_TARGET = '0;

    tick(); tick();
    check("rst.PC", bus0.PC, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, NOP, 1'b0);
    check("rst.exc", {31'd0, bus0.EXC_MISALIGN}, 32'd0);
    check("wrap.rstPC", bus1.PC, 32'hFFFFFFFC);
    check("wrap.addr", {22'd0, bus1.INS_ADDRESS}, 32'd1023);

    RST = 1'b0;
    tick();
    check("seq1.PC", bus0.PC, 32'h4);
    check_ifid("seq1", 32'h0, 32'h4, 32'hA0000000, 1'b1);
    check("wrap.nextPC", bus1.PC, 32'h0);
    check("wrap.ifid_pc", bus1.IF_ID_PC, 32'hFFFFFFFC);
    check("wrap.ifid_pc4", bus1.IF_ID_PC4, 32'h0);
    check("wrap.instr", bus1.IF_ID_INSTRUCTION, 32'hA00003FF);

    tick();
    check("seq2.PC", bus0.PC, 32'h8);
    check_ifid("seq2", 32'h4, 32'h8, 32'hA0000001, 1'b1);

    bus0.STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.PC", bus0.PC, 32'h8);
      check_ifid("stall", 32'h4, 32'h8, 32'hA0000001, 1'b1);
    end
    bus0.STALL = 1'b0;
    tick();
    check("unstall.PC", bus0.PC, 32'hC);
    check_ifid("unstall", 32'h8, 32'hC, 32'hA0000002, 1'b1);

    bus0.BRANCH_TAKEN = 1'b1; bus0.BRANCH_TARGET = 32'h40;
    tick();
    bus0.BRANCH_TAKEN = 1'b0;
    check("br.PC", bus0.PC, 32'h40);
    check_ifid("br", 32'h0, 32'h0, NOP, 1'b0);
    tick();
    check("br_next.PC", bus0.PC, 32'h44);
    check_ifid("br_next", 32'h40, 32'h44, 32'hA0000010, 1'b1);

    bus0.BRANCH_TAKEN = 1'b1; bus0.STALL = 1'b1; bus0.BRANCH_TARGET = 32'h20;
    tick();
    bus0.BRANCH_TAKEN = 1'b0; bus0.STALL = 1'b0;
    check("brstall.PC", bus0.PC, 32'h20);
    check_ifid("brstall", 32'h0, 32'h0, NOP, 1'b0);
    tick();
    check("seq3.PC", bus0.PC, 32'h24);
    check_ifid("seq3", 32'h20, 32'h24, 32'hA0000008, 1'b1);

    bus0.BRANCH_TAKEN = 1'b1; bus0.BRANCH_TARGET = 32'h22;
    tick();
    bus0.BRANCH_TAKEN = 1'b0;
    check_ifid("mis", 32'h0, 32'h0, NOP, 1'b0);
`ifdef FETCH_MISALIGN_EN
    check("mis.PC", bus0.PC, 32'h24);
    check("mis.exc", {31'd0, bus0.EXC_MISALIGN}, 32'd1);
`else
    check("mis.PC", bus0.PC, 32'h20);
    check("mis.exc", {31'd0, bus0.EXC_MISALIGN}, 32'd0);
`endif
    tick();
    check("mis_after.exc", {31'd0, bus0.EXC_MISALIGN}, 32'd0);
    check("mis_after.valid", {31'd0, bus0.IF_ID_VALID}, 32'd1);

    bus0.STALL = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    check("rststall.PC", bus0.PC, 32'h0);
    check_ifid("rststall", 32'h0, 32'h0, NOP, 1'b0);
    RST = 1'b0; bus0.STALL = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
